// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed hex 7-segment scan driver
//
// Latches DIGITS hex nibbles plus per-digit decimal points and shows them one at a
// time on a shared segment bus, selecting the visible digit with a one-hot enable.
//
// Parameters
//   DIGITS         number of digits scanned (1..8)
//   CLK_DIV        clk cycles each digit stays selected (>= 1)
//   SEG_ACTIVE_LOW 1: a lit segment drives 0
//   AN_ACTIVE_LOW  1: the selected digit drives 0
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   data       packed nibbles, digit k = data[4k+3:4k], digit 0 rightmost
//   points     decimal point per digit, 1 = lit
//   le         latch enable: 0 = capture every cycle, 1 = hold
//   lzb        leading-zero blanking enable
//   segment    {p,g,f,e,d,c,b,a}, registered, polarity per SEG_ACTIVE_LOW
//   an         one-hot digit enable, registered, polarity per AN_ACTIVE_LOW
//   scan_tick  one-cycle pulse after the scan index wraps back to digit 0

module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     points,
    input  logic                  le,
    input  logic                  lzb,
    output logic [7:0]            segment,
    output logic [DIGITS-1:0]     an,
    output logic                  scan_tick
);

    // Counter widths never drop below one bit so DIGITS=1 / CLK_DIV=1 stay legal.
    localparam int IW = (DIGITS > 1)  ? $clog2(DIGITS)  : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0]     DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);

    // Inactive output levels; XOR with these converts active-high to pin polarity.
    localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [4*DIGITS-1:0] latch_data;
    logic [DIGITS-1:0]   latch_pts;
    logic [CW-1:0]       div_cnt;
    logic [IW-1:0]       idx;
    logic                div_wrap;

    logic [3:0]          sel_nib;
    logic                sel_pt;
    logic                sel_zero;
    logic                zero_run;
    logic [DIGITS-1:0]   an_hot;
    logic                blank;
    logic [7:0]          seg_on;

    // Hex to active-high gfedcba. Every code is listed so no value decodes to X.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // Input latch: transparent while le=0, frozen while le=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_data <= '0;
            latch_pts  <= '0;
        end else if (!le) begin
            latch_data <= data;
            latch_pts  <= points;
        end
    end

    // Refresh prescaler: div_wrap marks the last cycle of a digit's slot.
    assign div_wrap = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_wrap) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Scan index and frame tick. IDX_LAST is 0 for a single digit, so idx stays 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= div_wrap && (idx == IDX_LAST);
            if (div_wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Select the current digit. Walking from the most significant digit down keeps
    // a running "everything from here upward is zero" flag for blanking.
    always_comb begin
        sel_nib  = 4'h0;
        sel_pt   = 1'b0;
        sel_zero = 1'b0;
        an_hot   = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (latch_data[4*k +: 4] == 4'h0);
            if (IW'(k) == idx) begin
                sel_nib   = latch_data[4*k +: 4];
                sel_pt    = latch_pts[k];
                sel_zero  = zero_run;
                an_hot[k] = 1'b1;
            end
        end
    end

    // Digit 0 always shows, so a zero value still reads "0" rather than nothing.
    assign blank  = lzb && (idx != '0) && sel_zero;
    assign seg_on = blank ? 8'h00 : {sel_pt, hex_decode(sel_nib)};

    // Registered outputs; reset drives both buses inactive without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segment <= SEG_OFF;
            an      <= AN_OFF;
        end else begin
            segment <= seg_on ^ SEG_OFF;
            an      <= an_hot ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver

module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  points;
    logic        le;
    logic        lzb;
    logic [7:0]  segment;
    logic [3:0]  an;
    logic        scan_tick;

    logic [3:0]  data1;
    logic        points1;
    logic [7:0]  segment1;
    logic        an1;
    logic        scan_tick1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .points(points), .le(le), .lzb(lzb),
        .segment(segment), .an(an), .scan_tick(scan_tick)
    );

    seg7_scan_driver #(.DIGITS(1), .CLK_DIV(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data(data1), .points(points1), .le(le), .lzb(lzb),
        .segment(segment1), .an(an1), .scan_tick(scan_tick1)
    );

    // Segment table (active-high gfedcba) for nibbles 0..F.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Active-high {p,gfedcba} for digit k of a latched word of nd digits.
    function automatic logic [7:0] lit(input logic [31:0] d, input logic [7:0] p,
                                       input int k, input logic bl);
        if (bl && k > 0 && (d >> (4 * k)) == 0) return 8'h00;
        return {p[k], seg_tab[int'((d >> (4 * k)) & 32'hF)]};
    endfunction

    // Reference model for the 4-digit instance: m_cnt edges since reset decide the
    // displayed digit, m_data/m_pts hold what the latch should contain.
    int unsigned m_cnt;
    logic [15:0] m_data;
    logic [3:0]  m_pts;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= 0;
            m_data   <= '0;
            m_pts    <= '0;
            exp_seg  <= 8'hFF;
            exp_an   <= 4'hF;
            exp_tick <= 1'b0;
        end else begin
            exp_seg  <= ~lit({16'h0, m_data}, {4'h0, m_pts}, int'((m_cnt / 4) % 4), lzb);
            exp_an   <= ~(4'b0001 << ((m_cnt / 4) % 4));
            exp_tick <= ((m_cnt + 1) % 16) == 0;
            m_cnt    <= m_cnt + 1;
            if (!le) begin
                m_data <= data;
                m_pts  <= points;
            end
        end
    end

    // Reference model for the single-digit, divide-by-1 instance.
    logic [3:0] m1_data;
    logic       m1_pts;
    logic [7:0] exp_seg1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_data  <= '0;
            m1_pts   <= 1'b0;
            exp_seg1 <= 8'hFF;
        end else begin
            exp_seg1 <= ~lit({28'h0, m1_data}, {7'h0, m1_pts}, 0, lzb);
            if (!le) begin
                m1_data <= data1;
                m1_pts  <= points1;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; data = '0; points = '0; le = 1'b0; lzb = 1'b0;
        data1 = '0; points1 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (segment !== 8'hFF || an !== 4'hF || scan_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: seg=%h an=%b tick=%b, want seg=ff an=1111 tick=0", segment, an, scan_tick);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (segment !== 8'hC0 || an !== 4'b1110 || scan_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge: seg=%h an=%b tick=%b, want seg=c0 an=1110 tick=0", segment, an, scan_tick);
        end
        for (int e = 2; e <= 20; e++) begin
            @(negedge clk);
            if (e == 4 || e == 5) begin
                n_checks++;
                if (an !== ((e == 4) ? 4'b1110 : 4'b1101)) begin
                    n_fail++;
                    $display("FAIL idx_advance edge %0d: an=%b", e, an);
                end
            end
            n_checks++;
            if (scan_tick !== (e == 16)) begin
                n_fail++;
                $display("FAIL scan_tick edge %0d: got %b want %b", e, scan_tick, (e == 16));
            end
        end
    endtask

    task automatic test_idle();
        int ticks = 0;
        repeat (64) begin
            @(negedge clk);
            ticks += scan_tick;
            n_checks++;
            if (segment !== exp_seg || an !== exp_an || scan_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL idle: seg=%h an=%b tick=%b, model seg=%h an=%b tick=%b",
                         segment, an, scan_tick, exp_seg, exp_an, exp_tick);
            end
        end
        n_checks++;
        if (ticks != 4) begin
            n_fail++;
            $display("FAIL tick_rate: %0d pulses in 64 cycles, want 4", ticks);
        end
    endtask

    task automatic test_sweep();
        lzb = 1'b0;
        for (int v = 0; v < 16; v++) begin
            logic [3:0] nib;
            nib = 4'(v);
            data = {12'h000, nib};
            points = {3'b000, nib[0]};
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                n_checks++;
                if (segment !== exp_seg || an !== exp_an || scan_tick !== exp_tick) begin
                    n_fail++;
                    $display("FAIL sweep %h: seg=%h an=%b, model seg=%h an=%b", nib, segment, an, exp_seg, exp_an);
                end
                if (c >= 2 && an === 4'b1110) begin
                    n_checks++;
                    if (segment[7] !== ~nib[0]) begin
                        n_fail++;
                        $display("FAIL sweep_point %h: p pin=%b", nib, segment[7]);
                    end
                    if (nib == 4'h8 || nib == 4'hF) begin
                        n_checks++;
                        if (segment !== ((nib == 4'h8) ? 8'h80 : 8'h0E)) begin
                            n_fail++;
                            $display("FAIL sweep_const %h: seg=%h", nib, segment);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_hold();
        lzb = 1'b0; le = 1'b0; data = 16'h1234; points = 4'b0100;
        repeat (3) @(negedge clk);
        le = 1'b1; data = 16'hFFFF; points = 4'b1111;
        repeat (48) begin
            @(negedge clk);
            n_checks++;
            if (segment !== exp_seg || an !== exp_an) begin
                n_fail++;
                $display("FAIL hold: seg=%h an=%b, model seg=%h an=%b", segment, an, exp_seg, exp_an);
            end
            n_checks++;
            if (segment === 8'h8E || segment === 8'h0E || (an === 4'b1011 && segment !== 8'h24)) begin
                n_fail++;
                $display("FAIL hold_const: seg=%h an=%b", segment, an);
            end
        end
        le = 1'b0;
    endtask

    task automatic test_lzb();
        lzb = 1'b1; le = 1'b0; points = 4'b0000; data = 16'h0070;
        for (int pass = 0; pass < 2; pass++) begin
            repeat (2) @(negedge clk);
            repeat (32) begin
                logic [7:0] want;
                @(negedge clk);
                n_checks++;
                if (segment !== exp_seg || an !== exp_an) begin
                    n_fail++;
                    $display("FAIL lzb_model: seg=%h an=%b, model seg=%h an=%b", segment, an, exp_seg, exp_an);
                end
                case (an)
                    4'b1110: want = 8'hC0;
                    4'b1101: want = (pass == 0) ? 8'hF8 : 8'hFF;
                    default: want = 8'hFF;
                endcase
                n_checks++;
                if (segment !== want) begin
                    n_fail++;
                    $display("FAIL lzb_const: an=%b seg=%h want %h", an, segment, want);
                end
            end
            data = 16'h0000;
        end
        lzb = 1'b0;
    endtask

    task automatic test_random();
        repeat (400) begin
            @(negedge clk);
            n_checks++;
            if (segment !== exp_seg || an !== exp_an || scan_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL random: seg=%h an=%b tick=%b, model seg=%h an=%b tick=%b",
                         segment, an, scan_tick, exp_seg, exp_an, exp_tick);
            end
            if ($urandom_range(0, 2) == 0) data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) points = 4'($urandom);
            if ($urandom_range(0, 7) == 0) le = ~le;
            if ($urandom_range(0, 9) == 0) lzb = ~lzb;
            if ($urandom_range(0, 5) == 0) data[15:8] = 8'h00;
        end
        le = 1'b0; lzb = 1'b0; points = 4'b0000;
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (exp_an == 4'b1011) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_reset_wait: digit 2 never selected within 64 cycles");
        end
        data = 16'h1234;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (segment !== 8'hFF || an !== 4'hF || scan_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: seg=%h an=%b tick=%b, want ff 1111 0", segment, an, scan_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (segment !== 8'hC0 || an !== 4'b1110) begin
            n_fail++;
            $display("FAIL post_reset: seg=%h an=%b, want c0 1110", segment, an);
        end
        @(negedge clk);
        n_checks++;
        if (segment !== 8'h99 || an !== 4'b1110) begin
            n_fail++;
            $display("FAIL post_reset_data: seg=%h an=%b, want 99 1110", segment, an);
        end
    endtask

    task automatic test_corner();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (segment1 !== 8'hFF || an1 !== 1'b1 || scan_tick1 !== 1'b0) begin
            n_fail++;
            $display("FAIL corner_reset: seg=%h an=%b tick=%b", segment1, an1, scan_tick1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        le = 1'b0;
        repeat (40) begin
            data1 = 4'($urandom);
            points1 = 1'($urandom);
            lzb = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (segment1 !== exp_seg1 || an1 !== 1'b0 || scan_tick1 !== 1'b1) begin
                n_fail++;
                $display("FAIL corner: seg=%h an=%b tick=%b, want seg=%h an=0 tick=1",
                         segment1, an1, scan_tick1, exp_seg1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_sweep();
        test_hold();
        test_lzb();
        test_random();
        test_mid_reset();
        test_corner();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
